// File: rtl/lpfilter_pkg.sv
// ============================================================================
// Module  : lpfilter_pkg
// Brief   : Shared defaults and width helpers for the lpfilter datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lpfilter_pkg;

    localparam int C_DWIDTH_DEF = 16;
    localparam int C_TAPS_DEF   = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Running sum needs log2(taps) guard bits above the sample width.
    function automatic int sum_width(input int dwidth, input int taps);
        return dwidth + clog2(taps);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpfilter_delayline.sv
// ============================================================================
// Module  : lpfilter_delayline
// Brief   : C_TAPS-deep sample shift register exposing the oldest tap.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lpfilter_delayline
    import lpfilter_pkg::*;
#(
    parameter int C_DWIDTH = C_DWIDTH_DEF,
    parameter int C_TAPS   = C_TAPS_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                shift_en,
    input  logic [C_DWIDTH-1:0] din,
    output logic [C_DWIDTH-1:0] oldest
);

    // Index 0 holds the newest sample, C_TAPS-1 the oldest.
    logic [C_TAPS-1:0][C_DWIDTH-1:0] taps;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            taps <= '0;
        end else if (shift_en) begin
            taps <= {taps[C_TAPS-2:0], din};
        end
    end

    assign oldest = taps[C_TAPS-1];

endmodule

`default_nettype wire

// File: rtl/lpfilter_stream.sv
// ============================================================================
// Module  : lpfilter_stream
// Brief   : Valid/ready moving-average low-pass filter with zero-inject drain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lpfilter_stream
    import lpfilter_pkg::*;
#(
    parameter int C_DWIDTH = C_DWIDTH_DEF,
    parameter int C_TAPS   = C_TAPS_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic signed [C_DWIDTH-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [C_DWIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       start_sync,
    output logic                       rdy
);

    localparam int SHIFT = clog2(C_TAPS);
    localparam int SW    = sum_width(C_DWIDTH, C_TAPS);

    logic                       adv;
    logic                       step;
    logic signed [C_DWIDTH-1:0] x;
    logic        [C_DWIDTH-1:0] oldest;
    logic signed [SW-1:0]       sum;
    logic signed [SW-1:0]       sum_next;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~start_sync;
    assign step     = start_sync ? adv : (in_valid & adv);
    assign rdy      = step;
    assign x        = start_sync ? '0 : in_data;

    assign sum_next = sum
                    + {{SHIFT{x[C_DWIDTH-1]}}, x}
                    - {{SHIFT{oldest[C_DWIDTH-1]}}, oldest};

    lpfilter_delayline #(
        .C_DWIDTH (C_DWIDTH),
        .C_TAPS   (C_TAPS)
    ) u_delay (
        .clk      (clk),
        .rstn     (rstn),
        .shift_en (step),
        .din      (x),
        .oldest   (oldest)
    );

    // Dropping the low SHIFT bits of a two's-complement sum is an
    // arithmetic right shift with floor rounding.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (step) begin
            sum       <= sum_next;
            out_data  <= sum_next[SW-1:SHIFT];
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lpfilter_stream.sv
// ============================================================================
// Module  : tb_lpfilter_stream
// Brief   : Directed plus random bench for lpfilter_stream against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpfilter_stream;

    localparam int DW   = 16;
    localparam int TAPS = 8;

    logic                 clk;
    logic                 rstn;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 start_sync;
    logic                 rdy;

    int total;
    int bad;

    int          hist[$];
    logic        ov_m;
    logic [15:0] od_m;
    logic        last_step;

    lpfilter_stream #(
        .C_DWIDTH (DW),
        .C_TAPS   (TAPS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .start_sync (start_sync),
        .rdy        (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fdiv(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < TAPS; i++) hist.push_back(0);
        ov_m = 1'b0;
        od_m = 16'h0;
    endtask

    // One clock cycle: drive, check handshake, advance model, check outputs.
    task automatic cyc(input logic iv, input logic [15:0] d, input logic orr, input logic ss);
        logic adv_m;
        logic st_m;
        int   x;
        int   tot;
        in_valid   = iv;
        in_data    = d;
        out_ready  = orr;
        start_sync = ss;
        #1;
        adv_m = !ov_m || orr;
        st_m  = ss ? adv_m : (iv && adv_m);
        chk("in_ready", {31'b0, in_ready}, {31'b0, adv_m && !ss});
        chk("rdy", {31'b0, rdy}, {31'b0, st_m});
        last_step = st_m;
        @(posedge clk);
        if (st_m) begin
            x = ss ? 0 : int'($signed(d));
            hist.push_front(x);
            void'(hist.pop_back());
            tot = 0;
            foreach (hist[i]) tot += hist[i];
            od_m = 16'(fdiv(tot, TAPS));
            ov_m = 1'b1;
        end else if (orr) begin
            ov_m = 1'b0;
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, ov_m});
        chk("out_data", {16'b0, out_data}, {16'b0, od_m});
    endtask

    task automatic async_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_sum", 32'(dut.sum), 32'd0);
        @(posedge clk);
        #1;
        rstn       = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        start_sync = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int          step_exp[8];
        int          drain_exp[8];
        int          nrdy;
        logic [15:0] held;
        total = 0;
        bad   = 0;
        step_exp  = '{12, 25, 37, 50, 62, 75, 87, 100};
        drain_exp = '{87, 75, 62, 50, 37, 25, 12, 0};
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; start_sync = 1'b0;
        model_reset();
        #3;
        async_reset();

        // Step response to a run of 100s.
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 16'd100, 1'b1, 1'b0);
            chk("step_const", {16'b0, out_data}, 32'(16'(step_exp[k])));
        end

        // Reset in the middle of a stream.
        cyc(1'b1, 16'd555, 1'b0, 1'b0);
        async_reset();

        // Signed floor: -1 then 0 both give -1.
        cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
        chk("floor_m1_a", {16'b0, out_data}, 32'h0000FFFF);
        cyc(1'b1, 16'h0000, 1'b1, 1'b0);
        chk("floor_m1_b", {16'b0, out_data}, 32'h0000FFFF);

        // Random traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        // Full-scale extremes.
        for (int k = 0; k < 10; k++) cyc(1'b1, 16'h7FFF, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cyc(1'b1, 16'h8000, 1'b1, 1'b0);

        // Backpressure for 5 cycles holds the output.
        cyc(1'b1, 16'd321, 1'b1, 1'b0);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
            chk("bp_hold", {16'b0, out_data}, {16'b0, held});
        end
        for (int k = 0; k < 4; k++) cyc(1'b1, 16'($urandom), 1'b1, 1'b0);

        // Steady 100, then drain with in_valid held high.
        for (int k = 0; k < 8; k++) cyc(1'b1, 16'd100, 1'b1, 1'b0);
        nrdy = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 16'($urandom), 1'b1, 1'b1);
            if (last_step) nrdy++;
            chk("drain_const", {16'b0, out_data}, 32'(16'(drain_exp[k])));
        end
        chk("drain_rdy_cnt", 32'(nrdy), 32'd8);
        chk("drain_sum", 32'(dut.sum), 32'd0);
        chk("drain_taps", 32'(|dut.u_delay.taps), 32'd0);

        // Resume normal acceptance straight after drain.
        for (int k = 0; k < 20; k++) cyc(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

        // Drain under stalls, counted like pipeline_sync with 8 steps.
        nrdy = 0;
        for (int k = 0; k < 200 && nrdy < 8; k++) begin
            cyc(1'b1, 16'($urandom), 1'($urandom_range(0, 2) != 0), 1'b1);
            if (last_step) nrdy++;
        end
        chk("sync_rdy_cnt", 32'(nrdy), 32'd8);
        chk("sync_sum", 32'(dut.sum), 32'd0);
        chk("sync_taps", 32'(|dut.u_delay.taps), 32'd0);
        chk("sync_out", {16'b0, out_data}, 32'd0);

        // Random mode toggling.
        for (int k = 0; k < 300; k++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 4) == 0));
        end

        // Reset mid-drain.
        cyc(1'b1, 16'd77, 1'b0, 1'b1);
        async_reset();
        cyc(1'b1, 16'd800, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
